pulse_sequencer: RTL



---
 rtl/pulse_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: period sync trigger, RF gate (pump + CPMG refocus train) and receiver-protect gate.
// Optional macro PULSE_EXT_TRIG_EN adds ext_trig and a WAIT state between periods.
module pulse_sequencer #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned SYNC_LEN   = 8,
   parameter int unsigned MIN_PERIOD = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] per,
   input  logic [CNT_W-1:0] p1wid,
   input  logic [CNT_W-1:0] del,
   input  logic [CNT_W-1:0] p2wid,
   input  logic             pu,
   input  logic [7:0]       cp,
   input  logic [7:0]       p_bl,
   input  logic [15:0]      p_bl_off,
   input  logic             bl,
`ifdef PULSE_EXT_TRIG_EN
   input  logic             ext_trig,
`endif
   output logic             sync_out,
   output logic             pulse_out,
   output logic             inhib_out
);

   localparam int unsigned EW = CNT_W + 2;

   // shadow copies of the parameter registers, refreshed only at period wrap
   logic [CNT_W-1:0] per_s, p1wid_s, del_s, p2wid_s;
   logic             pu_s, bl_s;
   logic [7:0]       cp_s, p_bl_s;
   logic [15:0]      p_bl_off_s;

   logic [CNT_W-1:0] cnt;
   logic [7:0]       k;
   logic [EW-1:0]    e_q;        // end of refocus pulse k; holds the last end once the train is done
   logic [EW-1:0]    prev_end;
   logic             prev_vld;

   logic [CNT_W-1:0] period_c;
   logic             wrap_c, run_c;
   logic [EW-1:0]    cnt_x, step_c, e_init_c, last_end_c;
   logic             active_k_c, adv_c, more_c;
   logic             pump_c, ref_c, pulse_c;
   logic             pump_guard_c, ref_guard_c, blk_on_c, inhib_c, sync_c;

`ifdef PULSE_EXT_TRIG_EN
   typedef enum logic {ST_WAIT, ST_RUN} state_t;
   state_t state;
   logic   trig_q;
   assign run_c = (state == ST_RUN) || (ext_trig && !trig_q);
`else
   assign run_c = 1'b1;
`endif

   // period, refocus schedule and output conditions for the current cnt
   always_comb begin
      cnt_x      = EW'(cnt);
      period_c   = (per_s < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : per_s;
      wrap_c     = (cnt == period_c - CNT_W'(1));
      step_c     = EW'(p2wid_s) + (EW'(del_s) << 1);
      e_init_c   = EW'(p1wid) + EW'(del) + EW'(p2wid);
      active_k_c = (k < cp_s);
      adv_c      = active_k_c && ((cnt_x + EW'(1)) >= e_q);
      more_c     = (9'(k) + 9'd1) < 9'(cp_s);

      pump_c  = pu_s && (cnt < p1wid_s);
      ref_c   = active_k_c && (cnt_x >= (e_q - EW'(p2wid_s))) && (cnt_x < e_q);
      pulse_c = pump_c || ref_c;

      pump_guard_c = pu_s && (p1wid_s != '0) && (cnt >= p1wid_s)
                     && (cnt_x < (EW'(p1wid_s) + EW'(p_bl_s)));
      ref_guard_c  = prev_vld && (cnt_x >= prev_end) && (cnt_x < (prev_end + EW'(p_bl_s)));

      last_end_c = '0;
      if (cp_s != 8'd0)
         last_end_c = e_q;
      else if (pu_s)
         last_end_c = EW'(p1wid_s);
      blk_on_c = cnt_x < (last_end_c + EW'(p_bl_off_s));

      inhib_c = bl_s ? blk_on_c : (pulse_c || pump_guard_c || ref_guard_c);
      sync_c  = cnt_x < EW'(SYNC_LEN);
   end

   always_ff @(posedge clk) begin
`ifdef PULSE_EXT_TRIG_EN
      trig_q <= ext_trig;
`endif
      if (reset) begin
         cnt        <= '0;
         k          <= '0;
         e_q        <= e_init_c;
         prev_end   <= '0;
         prev_vld   <= 1'b0;
         sync_out   <= 1'b0;
         pulse_out  <= 1'b0;
         inhib_out  <= 1'b0;
         per_s      <= per;
         p1wid_s    <= p1wid;
         del_s      <= del;
         p2wid_s    <= p2wid;
         pu_s       <= pu;
         cp_s       <= cp;
         p_bl_s     <= p_bl;
         p_bl_off_s <= p_bl_off;
         bl_s       <= bl;
`ifdef PULSE_EXT_TRIG_EN
         state      <= ST_WAIT;
`endif
      end else if (!run_c) begin
         sync_out  <= 1'b0;
         pulse_out <= 1'b0;
         inhib_out <= 1'b0;
      end else begin
         sync_out  <= sync_c;
         pulse_out <= pulse_c;
         inhib_out <= inhib_c;
         if (wrap_c) begin
            cnt        <= '0;
            k          <= '0;
            e_q        <= e_init_c;
            prev_vld   <= 1'b0;
            per_s      <= per;
            p1wid_s    <= p1wid;
            del_s      <= del;
            p2wid_s    <= p2wid;
            pu_s       <= pu;
            cp_s       <= cp;
            p_bl_s     <= p_bl;
            p_bl_off_s <= p_bl_off;
            bl_s       <= bl;
`ifdef PULSE_EXT_TRIG_EN
            state      <= ST_WAIT;
`endif
         end else begin
            cnt <= cnt + CNT_W'(1);
`ifdef PULSE_EXT_TRIG_EN
            state <= ST_RUN;
`endif
            // last cycle of pulse k: move to the next one, keep e_q at the final end
            if (adv_c) begin
               k <= k + 8'd1;
               if (more_c)
                  e_q <= e_q + step_c;
               if (p2wid_s != '0) begin
                  prev_end <= e_q;
                  prev_vld <= 1'b1;
               end
            end
         end
      end
   end

endmodule
